// File: rtl/rep_str_seq.sv
// EX-stage sequencer for string instructions (MOVS/CMPS/STOS/LODS with optional REP/REPE/REPNE).
// Steps memory accesses, ESI/EDI updates via ALU1 and the ECX count; holds the pipeline until retire.
module rep_str_seq #(
    parameter int unsigned CNT_W   = 32,
    parameter logic [3:0]  OP_PTR  = 4'b1010,
    parameter logic [3:0]  OP_PASS = 4'b0100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       str_op,
    input  logic [1:0]       rep_mode,
    input  logic [CNT_W-1:0] ecx_in,
    input  logic             stall,
    input  logic             mem_rd_done,
    input  logic             mem_wr_done,
    input  logic             cmps_zf,
    output logic             busy,
    output logic [3:0]       alu1_op,
    output logic             ptr_sel,
    output logic             ld_esi,
    output logic             ld_edi,
    output logic             mem_rd_req,
    output logic             mem_wr_req,
    output logic             mem_lat_en,
    output logic             ld_cmps_flags,
    output logic             ecx_wr,
    output logic [CNT_W-1:0] ecx_out,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DST,
        S_WR,
        S_UPD_SI,
        S_UPD_DI,
        S_CNT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MOVS = 2'b00,
        OP_CMPS = 2'b01,
        OP_STOS = 2'b10,
        OP_LODS = 2'b11
    } str_op_e;

    typedef enum logic [1:0] {
        REP_NONE = 2'b00,
        REP_E    = 2'b01,
        REP_NE   = 2'b10,
        REP_RSVD = 2'b11
    } rep_e;

    state_e           state_q, state_d;
    str_op_e          op_q, op_d;
    rep_e             rep_q, rep_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             zf_q, zf_d;

    logic [CNT_W-1:0] cnt_dec;
    rep_e             rep_in;
    state_e           first_in;
    state_e           first_q;
    logic             term;

    always_comb begin
        cnt_dec  = cnt_q - CNT_W'(1);
        rep_in   = (rep_mode == REP_RSVD) ? REP_NONE : rep_e'(rep_mode);
        first_in = (str_op == OP_STOS) ? S_WR : S_RD_SRC;
        first_q  = (op_q == OP_STOS) ? S_WR : S_RD_SRC;
        // REPE/REPNE only consult ZF for CMPS; other ops fall back to plain REP
        term     = (cnt_dec == '0)
                 || ((op_q == OP_CMPS) && (rep_q == REP_E)  && !zf_q)
                 || ((op_q == OP_CMPS) && (rep_q == REP_NE) &&  zf_q);
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rep_d         = rep_q;
        cnt_d         = cnt_q;
        zf_d          = zf_q;
        busy          = 1'b0;
        alu1_op       = OP_PASS;
        ptr_sel       = 1'b0;
        ld_esi        = 1'b0;
        ld_edi        = 1'b0;
        mem_rd_req    = 1'b0;
        mem_wr_req    = 1'b0;
        mem_lat_en    = 1'b0;
        ld_cmps_flags = 1'b0;
        ecx_wr        = 1'b0;
        ecx_out       = '0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d  = str_op_e'(str_op);
                    rep_d = rep_in;
                    cnt_d = ecx_in;
                    if ((rep_in != REP_NONE) && (ecx_in == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = first_in;
                    end
                end
            end
            S_RD_SRC: begin
                busy       = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_rd_done) begin
                    mem_lat_en = 1'b1;
                    case (op_q)
                        OP_CMPS: state_d = S_RD_DST;
                        OP_MOVS: state_d = S_WR;
                        default: state_d = S_UPD_SI;
                    endcase
                end
            end
            S_RD_DST: begin
                busy       = 1'b1;
                ptr_sel    = 1'b1;
                mem_rd_req = 1'b1;
                if (mem_rd_done) begin
                    ld_cmps_flags = 1'b1;
                    zf_d          = cmps_zf;
                    state_d       = S_UPD_SI;
                end
            end
            S_WR: begin
                busy       = 1'b1;
                mem_wr_req = 1'b1;
                if (mem_wr_done) begin
                    state_d = (op_q == OP_MOVS) ? S_UPD_SI : S_UPD_DI;
                end
            end
            S_UPD_SI: begin
                busy    = 1'b1;
                alu1_op = OP_PTR;
                ld_esi  = 1'b1;
                state_d = (op_q == OP_LODS) ? S_CNT : S_UPD_DI;
            end
            S_UPD_DI: begin
                busy    = 1'b1;
                alu1_op = OP_PTR;
                ptr_sel = 1'b1;
                ld_edi  = 1'b1;
                state_d = S_CNT;
            end
            S_CNT: begin
                busy = 1'b1;
                if (rep_q == REP_NONE) begin
                    state_d = S_DONE;
                end else begin
                    ecx_wr  = 1'b1;
                    ecx_out = cnt_dec;
                    cnt_d   = cnt_dec;
                    state_d = term ? S_DONE : first_q;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Stall freezes all state (done inputs included) and suppresses every
        // one-cycle side effect; request levels stay up so memory keeps them.
        if (stall) begin
            state_d       = state_q;
            op_d          = op_q;
            rep_d         = rep_q;
            cnt_d         = cnt_q;
            zf_d          = zf_q;
            ld_esi        = 1'b0;
            ld_edi        = 1'b0;
            ecx_wr        = 1'b0;
            ld_cmps_flags = 1'b0;
            mem_lat_en    = 1'b0;
            done          = 1'b0;
        end

        // Reset drops requests and register writes in the same cycle it is seen.
        if (rst) begin
            busy          = 1'b0;
            alu1_op       = OP_PASS;
            ptr_sel       = 1'b0;
            ld_esi        = 1'b0;
            ld_edi        = 1'b0;
            mem_rd_req    = 1'b0;
            mem_wr_req    = 1'b0;
            mem_lat_en    = 1'b0;
            ld_cmps_flags = 1'b0;
            ecx_wr        = 1'b0;
            ecx_out       = '0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MOVS;
            rep_q   <= REP_NONE;
            cnt_q   <= '0;
            zf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rep_q   <= rep_d;
            cnt_q   <= cnt_d;
            zf_q    <= zf_d;
        end
    end

endmodule
